// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch initiator with prefetch FIFO and redirect
module ifetch_unit #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_en,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       fetch_fault,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc;
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic in_range_fail;
    logic full;
    logic pop;
    logic push;

    // Only the word part of a redirect target matters.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

    assign imem_addr     = {2'b00, pc[31:2]};
    assign in_range_fail = ({2'b00, pc[31:2]} >= 32'(MEM_WORDS));
    assign full          = (count == CW'(DEPTH));
    assign out_valid     = (count != '0);
    assign pop           = out_valid & out_ready;
    // A full FIFO can still accept a word when the head leaves on the same edge.
    assign push          = fetch_en & ~redirect_valid & ~fetch_fault & ~in_range_fail &
                           (~full | pop);

    assign out_instr  = out_valid ? fifo_instr[rd_ptr] : 32'h0;
    assign out_pc     = out_valid ? fifo_pc[rd_ptr]    : 32'h0;
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= {RESET_PC[31:2], 2'b00};
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            fetch_fault <= 1'b0;
        end else if (redirect_valid) begin
            pc          <= {redirect_pc[31:2], 2'b00};
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            fetch_fault <= 1'b0;
        end else begin
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (fetch_en && in_range_fail) begin
                fetch_fault <= 1'b1;
            end
        end
    end

    // Entry storage needs no reset: count gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_pc[wr_ptr]    <= pc;
            fifo_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit against a queue model
module tb_ifetch_unit;
    localparam int DEPTH     = 4;
    localparam int MEM_WORDS = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [MEM_WORDS];

    // Reference state: a plain queue of {pc, instr} entries.
    logic [63:0] mq [$];
    logic [31:0] m_pc;
    logic        m_fault;

    always #5 clk = ~clk;

    assign imem_rdata = (imem_addr < MEM_WORDS) ? mem[imem_addr[7:0]] : 32'hDEAD_BEEF;

    ifetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0), .MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_fault(fetch_fault), .fifo_count(fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        logic        v;
        v = (mq.size() != 0);
        chk("out_valid",  {31'b0, out_valid}, {31'b0, v});
        chk("out_pc",     out_pc,    v ? mq[0][63:32] : 32'h0);
        chk("out_instr",  out_instr, v ? mq[0][31:0]  : 32'h0);
        chk("fifo_count", {29'b0, fifo_count}, mq.size());
        chk("fault",      {31'b0, fetch_fault}, {31'b0, m_fault});
        chk("imem_addr",  imem_addr, m_pc >> 2);
    endtask

    task automatic step(input logic fe, input logic rdy, input logic rv,
                        input logic [31:0] rpc, input logic r);
        logic do_pop, do_push, oob;
        fetch_en = fe; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc; rst = r;
        #1;
        compare_model();
        oob = (m_pc >> 2) >= MEM_WORDS;
        if (r) begin
            mq.delete(); m_pc = 32'h0; m_fault = 1'b0;
        end else if (rv) begin
            mq.delete(); m_pc = rpc & ~32'h3; m_fault = 1'b0;
        end else begin
            do_pop  = (mq.size() != 0) && rdy;
            do_push = fe && !m_fault && !oob && ((mq.size() < DEPTH) || do_pop);
            if (fe && oob) m_fault = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back({m_pc, mem[m_pc[9:2]]});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < MEM_WORDS; k++) mem[k] = 32'h100 + k;
        m_pc = 32'h0; m_fault = 1'b0;
        rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(posedge clk); #1;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("reset_valid", {31'b0, out_valid}, 32'h0);
        chk("reset_count", {29'b0, fifo_count}, 32'h0);

        // Streaming with decode always ready
        step(1, 1, 0, 0, 0);
        chk("t1_valid", {31'b0, out_valid}, 32'h1);
        chk("t1_pc0", out_pc, 32'h0);
        chk("t1_instr0", out_instr, 32'h100);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0);

        // Back-pressure saturation then drain
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
        chk("t2_count", {29'b0, fifo_count}, 32'h4);
        chk("t2_pc", imem_addr, 32'h4);
        chk("t2_head", out_pc, 32'h0);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0);

        // Redirect flushes three entries
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        chk("t3_pre_count", {29'b0, fifo_count}, 32'h3);
        step(1, 1, 1, 32'h42, 0);
        chk("t3_count", {29'b0, fifo_count}, 32'h0);
        chk("t3_valid", {31'b0, out_valid}, 32'h0);
        step(1, 0, 0, 0, 0);
        chk("t3_pc", out_pc, 32'h40);
        chk("t3_instr", out_instr, 32'h110);

        // Fetch off the end of memory
        step(1, 0, 1, 32'h3FC, 0);
        step(1, 0, 0, 0, 0);
        chk("t4_last_pc", out_pc, 32'h3FC);
        step(1, 0, 0, 0, 0);
        chk("t4_fault", {31'b0, fetch_fault}, 32'h1);
        chk("t4_hold", imem_addr, 32'h100);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        chk("t4_drained", {29'b0, fifo_count}, 32'h0);
        step(1, 1, 1, 32'h0, 0);
        chk("t4_clear", {31'b0, fetch_fault}, 32'h0);
        step(1, 1, 0, 0, 0);
        chk("t4_resume", out_instr, 32'h100);

        // fetch_en toggling, then reset mid-stream
        for (int i = 0; i < 8; i++) step(i[0] ? 1'b0 : 1'b1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        chk("t5_valid", {31'b0, out_valid}, 32'h0);
        chk("t5_pc", imem_addr, 32'h0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0);
            chk("t6_count", {29'b0, fifo_count}, 32'h4);
        end

        // Randomized traffic with random memory contents
        for (int k = 0; k < MEM_WORDS; k++) mem[k] = $urandom;
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 11) == 0), $urandom_range(0, 32'h4FF),
                 ($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
